// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan controller: hex glyphs, off patterns, FSM encoding.
package seg_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_DRIVE = 1'b0;
  localparam state_t ST_GUARD = 1'b1;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a}; b and d are lowercase glyphs
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Index of the most-significant nonzero nibble; 0 when the value is zero
  function automatic logic [1:0] msd_index(input logic [15:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[7:4]   != 4'h0) idx = 2'd1;
    if (v[11:8]  != 4'h0) idx = 2'd2;
    if (v[15:12] != 4'h0) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/hex_seg_digit.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_seg_digit
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    case (nibble)
      4'h0: seg_n = SEG_0;
      4'h1: seg_n = SEG_1;
      4'h2: seg_n = SEG_2;
      4'h3: seg_n = SEG_3;
      4'h4: seg_n = SEG_4;
      4'h5: seg_n = SEG_5;
      4'h6: seg_n = SEG_6;
      4'h7: seg_n = SEG_7;
      4'h8: seg_n = SEG_8;
      4'h9: seg_n = SEG_9;
      4'hA: seg_n = SEG_A;
      4'hB: seg_n = SEG_B;
      4'hC: seg_n = SEG_C;
      4'hD: seg_n = SEG_D;
      4'hE: seg_n = SEG_E;
      4'hF: seg_n = SEG_F;
      default: seg_n = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with guard gaps and frame-synchronous updates.
// Define SEG_LZ_BLANK_EN to suppress leading-zero digits.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int GUARD = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  input  logic        blank,
  output logic [6:0]  seg_n,
  output logic [3:0]  an_n
);

  localparam int MAXLEN = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW     = $clog2(MAXLEN + 1);
  localparam logic [CW-1:0] DWELL_C = CW'(DWELL);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t        state, state_nx;
  logic [1:0]    digit, digit_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [15:0]   display, display_nx;
  logic [15:0]   shadow;
  logic          pending, pending_nx;
  logic          accept, boundary;
  logic [3:0]    nib;
  logic [6:0]    dec_seg;
  logic          digit_lit;
  logic [6:0]    seg_nx;
  logic [3:0]    an_nx;

  // cnt is the number of cycles already spent in the current state, so the
  // reset value 0 gives the first GUARD one extra cycle before counting starts
  always_comb begin
    accept     = in_valid && in_ready;
    boundary   = (state == ST_GUARD) && (digit == 2'd3) && (cnt == GUARD_C);
    state_nx   = state;
    digit_nx   = digit;
    cnt_nx     = cnt + ONE_C;
    if (state == ST_DRIVE) begin
      if (cnt == DWELL_C) begin
        state_nx = ST_GUARD;
        cnt_nx   = ONE_C;
      end
    end else begin
      if (cnt == GUARD_C) begin
        state_nx = ST_DRIVE;
        digit_nx = digit + 2'd1;
        cnt_nx   = ONE_C;
      end
    end
    display_nx = (boundary && pending) ? shadow : display;
    if (accept)        pending_nx = 1'b1;
    else if (boundary) pending_nx = 1'b0;
    else               pending_nx = pending;
  end

  // Outputs are decoded from next-state values so the registers line up with the FSM
  always_comb begin
    nib = 4'h0;
    case (digit_nx)
      2'd0: nib = display_nx[3:0];
      2'd1: nib = display_nx[7:4];
      2'd2: nib = display_nx[11:8];
      2'd3: nib = display_nx[15:12];
      default: nib = 4'h0;
    endcase
`ifdef SEG_LZ_BLANK_EN
    digit_lit = (digit_nx <= msd_index(display_nx));
`else
    digit_lit = 1'b1;
`endif
    seg_nx = SEG_OFF;
    an_nx  = AN_OFF;
    if (state_nx == ST_DRIVE && !blank) begin
      an_nx = ~(4'b0001 << digit_nx);
      if (digit_lit) seg_nx = dec_seg;
    end
  end

  hex_seg_digit u_dec (
    .nibble (nib),
    .seg_n  (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_GUARD;
      digit    <= 2'd3;
      cnt      <= '0;
      display  <= 16'h0000;
      shadow   <= 16'h0000;
      pending  <= 1'b0;
      in_ready <= 1'b0;
      seg_n    <= SEG_OFF;
      an_n     <= AN_OFF;
    end else begin
      state    <= state_nx;
      digit    <= digit_nx;
      cnt      <= cnt_nx;
      display  <= display_nx;
      if (accept) shadow <= in_data;
      pending  <= pending_nx;
      in_ready <= !pending_nx;
      seg_n    <= seg_nx;
      an_n     <= an_nx;
    end
  end

endmodule
